symm_conv_check: RTL and testbench
==================================

Name: symm_conv_check

Overview:
- Consumes the 16 element-wise deviation magnitudes |W·Wᵀ − I| produced by the symmetric-decorrelation absolute-value stage. Format: 26-bit signed, Q13, 8192 = 1.0.
- Serially scans the 16 values for the maximum and compares it against a tolerance.
- Keeps the FastICA outer-iteration count.
- Tells the controller whether to stop (converged), run another iteration, or give up (timeout).

Parameters:
- DW, 26, data width of each deviation input and of max_dev.
- TOL, 82, convergence tolerance in Q13 (≈0.01); converged when max ≤ TOL.
- MAX_ITER, 64, maximum outer iterations before timeout; legal range 1..255.
- ITER_W, 8, width of iter_cnt.

Ports:
- clk_conv  input  1  clock; all logic on the rising edge.
- rst_conv  input  1  synchronous, active-high reset.
- start_conv  input  1  request one check pass; sampled only in IDLE.
- clear_iter  input  1  clear the iteration counter and the sticky timeout; sampled only in IDLE.
- d11..d44  input  DW each (16 ports, signed)  deviation matrix, row-major; index = 4·(row−1)+(col−1).
- busy  output  1  pass in progress.
- done  output  1  one-cycle pulse when the verdict is valid.
- converged  output  1  last verdict: max_dev ≤ TOL.
- next_iter  output  1  last verdict: not converged and not timed out.
- timeout  output  1  sticky; iteration limit reached without convergence.
- max_dev  output  DW  maximum magnitude of the last pass.
- max_idx  output  4  index 0..15 of the first occurrence of max_dev.
- iter_cnt  output  ITER_W  number of completed passes since reset or clear.

Behaviour:
- Reset: every output 0; state IDLE; internal latch registers, scan index and running max all 0. Reset mid-pass aborts the pass with no done.
- FSM states: IDLE, SCAN, DECIDE.
- IDLE:
  - If clear_iter = 1: iter_cnt ← 0 and timeout ← 0.
  - If start_conv = 1 and timeout = 0 (after applying any clear in the same cycle): latch all 16 inputs, running max ← 0, idx ← 0, busy ← 1, clear converged/next_iter, go to SCAN.
  - start_conv while timeout = 1 is ignored.
- SCAN: one element per cycle, idx 0..15.
  - Element magnitude: its value if the sign bit is 0; saturated to 2^(DW−1)−1 (0x1FFFFFF) if the sign bit is 1. A negative value indicates an upstream fault and must never converge.
  - Update max and max_idx only on strictly greater, so ties keep the lower index.
  - After idx 15 go to DECIDE; idx never wraps.
- DECIDE (single cycle): register max_dev and max_idx; iter_cnt ← iter_cnt+1, saturating at 255.
  - If max ≤ TOL: converged ← 1.
  - Else if the new iter_cnt ≥ MAX_ITER: timeout ← 1.
  - Else: next_iter ← 1.
  - done ← 1 and busy ← 0 for exactly one cycle; return to IDLE.
- Latency: start_conv sampled at edge N gives busy = 1 after edge N, done = 1 after edge N+17 for one cycle, busy = 0 in that same cycle. A new start may be sampled at edge N+18 at the earliest.
- Inputs are captured only at edge N; later changes do not affect the pass.
- start_conv and clear_iter while busy are ignored.
- converged, next_iter, timeout, max_dev, max_idx and iter_cnt hold until the next accepted start (converged/next_iter clear), clear_iter (iter_cnt/timeout clear) or reset.
- Exactly one of converged/next_iter/timeout is set after any done.
- Comparisons are signed DW-bit. TOL must be non-negative.

Test Plan:
- Reset, all d = 0, start at edge N → done only after edge N+17, busy high for 17 cycles, converged = 1, max_dev = 0, max_idx = 0, iter_cnt = 1, next_iter = 0.
- d23 = 500, others 10, TOL = 82 → max_dev = 500, max_idx = 6, converged = 0, next_iter = 1, iter_cnt = 1. Boundary: d23 = 82 → converged = 1; d23 = 83 → next_iter = 1.
- d12 = d41 = 300, others 0 → max_idx = 1, max_dev = 300. Change d12 to 0 during SCAN → result unchanged.
- d44 = −5, others 0 → max_dev = 0x1FFFFFF, max_idx = 15, next_iter = 1.
- MAX_ITER = 3, d11 = 1000 held, three passes → done with next_iter on passes 1–2 and timeout = 1 on pass 3 (iter_cnt = 3); a 4th start gives no busy/done. Assert clear_iter and start_conv together → iter_cnt = 0 then 1 after the pass, timeout = 0.
- Reset asserted at SCAN idx 7 → all outputs 0 next cycle, no done pulse. Start during busy → ignored, exactly one done. A fresh start after reset → normal verdict 18 cycles later.

Source files
------------

// File: rtl/symm_conv_check.sv
// symm_conv_check: scans the 16 deviation magnitudes of |W*W^T - I| for
// their maximum, compares it with a tolerance and tracks the FastICA
// outer-iteration count. Each verdict is exactly one of converged,
// next_iter or timeout.
module symm_conv_check #(
    parameter int DW       = 26,
    parameter int TOL      = 82,
    parameter int MAX_ITER = 64,
    parameter int ITER_W   = 8
) (
    input  logic                 clk_conv,
    input  logic                 rst_conv,
    input  logic                 start_conv,
    input  logic                 clear_iter,
    input  logic signed [DW-1:0] d11,
    input  logic signed [DW-1:0] d12,
    input  logic signed [DW-1:0] d13,
    input  logic signed [DW-1:0] d14,
    input  logic signed [DW-1:0] d21,
    input  logic signed [DW-1:0] d22,
    input  logic signed [DW-1:0] d23,
    input  logic signed [DW-1:0] d24,
    input  logic signed [DW-1:0] d31,
    input  logic signed [DW-1:0] d32,
    input  logic signed [DW-1:0] d33,
    input  logic signed [DW-1:0] d34,
    input  logic signed [DW-1:0] d41,
    input  logic signed [DW-1:0] d42,
    input  logic signed [DW-1:0] d43,
    input  logic signed [DW-1:0] d44,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic                 next_iter,
    output logic                 timeout,
    output logic signed [DW-1:0] max_dev,
    output logic [3:0]           max_idx,
    output logic [ITER_W-1:0]    iter_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DECIDE
    } state_t;

    localparam logic signed [DW-1:0] L_TOL     = DW'(TOL);
    localparam logic signed [DW-1:0] L_SAT     = {1'b0, {(DW-1){1'b1}}};
    localparam logic [ITER_W-1:0]    L_ITER_MX = '1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic signed [DW-1:0]  r_lat [16];
    logic signed [DW-1:0]  w_d [16];
    logic [3:0]            r_idx;
    logic signed [DW-1:0]  r_max;
    logic [3:0]            r_run_idx;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_conv;
    logic                  r_next;
    logic                  r_timeout;
    logic signed [DW-1:0]  r_max_dev;
    logic [3:0]            r_max_idx;
    logic [ITER_W-1:0]     r_iter;

    logic                  w_accept;
    logic                  w_timeout_eff;
    logic signed [DW-1:0]  w_cur;
    logic signed [DW-1:0]  w_mag;
    logic [ITER_W-1:0]     w_iter_inc;
    logic                  w_is_conv;
    logic                  w_hit_limit;

    // Row-major view of the input matrix: index = 4*(row-1) + (col-1).
    assign w_d[0]  = d11;
    assign w_d[1]  = d12;
    assign w_d[2]  = d13;
    assign w_d[3]  = d14;
    assign w_d[4]  = d21;
    assign w_d[5]  = d22;
    assign w_d[6]  = d23;
    assign w_d[7]  = d24;
    assign w_d[8]  = d31;
    assign w_d[9]  = d32;
    assign w_d[10] = d33;
    assign w_d[11] = d34;
    assign w_d[12] = d41;
    assign w_d[13] = d42;
    assign w_d[14] = d43;
    assign w_d[15] = d44;

    // A negative deviation signals an upstream fault; saturating it to the
    // largest positive value guarantees it can never pass the tolerance.
    assign w_cur = r_lat[r_idx];
    assign w_mag = w_cur[DW-1] ? L_SAT : w_cur;

    assign w_iter_inc  = (r_iter == L_ITER_MX) ? r_iter : r_iter + 1'b1;
    assign w_is_conv   = (r_max <= L_TOL);
    assign w_hit_limit = (int'(w_iter_inc) >= MAX_ITER);

    // A clear in the same cycle lifts the timeout before start is judged.
    assign w_timeout_eff = clear_iter ? 1'b0 : r_timeout;

    // State register.
    always_ff @(posedge clk_conv) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst_conv) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and the start-acceptance strobe.
    always_comb begin
        // NOTE: defaults first, so no path leaves a variable unassigned and
        // no latch is inferred.
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_conv && !w_timeout_eff) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_idx == 4'd15) begin
                    w_state_nxt = S_DECIDE;
                end
            end
            S_DECIDE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture, serial max scan, verdict and iteration bookkeeping.
    always_ff @(posedge clk_conv) begin
        if (rst_conv) begin
            // NOTE: the capture array is small and must read as zero after
            // reset, so it is cleared here like any other register.
            for (int i = 0; i < 16; i++) begin
                r_lat[i] <= '0;
            end
            r_idx     <= '0;
            r_max     <= '0;
            r_run_idx <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_conv    <= 1'b0;
            r_next    <= 1'b0;
            r_timeout <= 1'b0;
            r_max_dev <= '0;
            r_max_idx <= '0;
            r_iter    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clear_iter) begin
                        r_iter    <= '0;
                        r_timeout <= 1'b0;
                    end
                    if (w_accept) begin
                        for (int i = 0; i < 16; i++) begin
                            r_lat[i] <= w_d[i];
                        end
                        r_max     <= '0;
                        r_run_idx <= '0;
                        r_idx     <= '0;
                        r_busy    <= 1'b1;
                        r_conv    <= 1'b0;
                        r_next    <= 1'b0;
                    end
                end
                S_SCAN: begin
                    // Strictly greater only, so ties keep the lower index.
                    if (w_mag > r_max) begin
                        r_max     <= w_mag;
                        r_run_idx <= r_idx;
                    end
                    if (r_idx != 4'd15) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DECIDE: begin
                    r_max_dev <= r_max;
                    r_max_idx <= r_run_idx;
                    r_iter    <= w_iter_inc;
                    if (w_is_conv) begin
                        r_conv <= 1'b1;
                    end else if (w_hit_limit) begin
                        r_timeout <= 1'b1;
                    end else begin
                        r_next <= 1'b1;
                    end
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign converged = r_conv;
    assign next_iter = r_next;
    assign timeout   = r_timeout;
    assign max_dev   = r_max_dev;
    assign max_idx   = r_max_idx;
    assign iter_cnt  = r_iter;

endmodule

// File: tb/tb_symm_conv_check.sv
// tb_symm_conv_check: directed checks of symm_conv_check. The main instance
// uses default parameters; a second instance with MAX_ITER = 3 covers the
// timeout path. Both share the clock, reset and deviation inputs.
module tb_symm_conv_check;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start0, clear0, start3, clear3;
    logic signed [25:0] d [16];

    logic               busy0, done0, conv0, next0, to0;
    logic signed [25:0] max0;
    logic [3:0]         idx0;
    logic [7:0]         it0;
    logic               busy3, done3, conv3, next3, to3;
    logic signed [25:0] max3;
    logic [3:0]         idx3;
    logic [7:0]         it3;

    symm_conv_check dut (
        .clk_conv(clk), .rst_conv(rst), .start_conv(start0), .clear_iter(clear0),
        .d11(d[0]),  .d12(d[1]),  .d13(d[2]),  .d14(d[3]),
        .d21(d[4]),  .d22(d[5]),  .d23(d[6]),  .d24(d[7]),
        .d31(d[8]),  .d32(d[9]),  .d33(d[10]), .d34(d[11]),
        .d41(d[12]), .d42(d[13]), .d43(d[14]), .d44(d[15]),
        .busy(busy0), .done(done0), .converged(conv0), .next_iter(next0),
        .timeout(to0), .max_dev(max0), .max_idx(idx0), .iter_cnt(it0)
    );

    symm_conv_check #(.MAX_ITER(3)) dut3 (
        .clk_conv(clk), .rst_conv(rst), .start_conv(start3), .clear_iter(clear3),
        .d11(d[0]),  .d12(d[1]),  .d13(d[2]),  .d14(d[3]),
        .d21(d[4]),  .d22(d[5]),  .d23(d[6]),  .d24(d[7]),
        .d31(d[8]),  .d32(d[9]),  .d33(d[10]), .d34(d[11]),
        .d41(d[12]), .d42(d[13]), .d43(d[14]), .d44(d[15]),
        .busy(busy3), .done(done3), .converged(conv3), .next_iter(next3),
        .timeout(to3), .max_dev(max3), .max_idx(idx3), .iter_cnt(it3)
    );

    // Observation mux: sel = 1 watches the MAX_ITER = 3 instance.
    bit sel = 1'b0;
    wire        o_busy = sel ? busy3 : busy0;
    wire        o_done = sel ? done3 : done0;
    wire        o_conv = sel ? conv3 : conv0;
    wire        o_next = sel ? next3 : next0;
    wire        o_to   = sel ? to3   : to0;
    wire [25:0] o_max  = sel ? max3  : max0;
    wire [3:0]  o_idx  = sel ? idx3  : idx0;
    wire [7:0]  o_it   = sel ? it3   : it0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic s, input logic c);
        if (sel) begin
            start3 = s;
            clear3 = c;
        end else begin
            start0 = s;
            clear0 = c;
        end
    endtask

    task automatic set_d(input int hot, input logic signed [25:0] hv,
                         input logic signed [25:0] bg);
        for (int i = 0; i < 16; i++) d[i] = (i == hot) ? hv : bg;
    endtask

    // One pass: start (optionally with clear), optional input change right
    // after capture, optional start+clear poke while busy. Checks latency
    // 17, 17 busy cycles and busy low alongside done.
    task automatic do_pass(input string tag, input bit with_clear, input int chg_idx,
                           input logic signed [25:0] chg_val, input bit poke);
        int lat;
        int bcnt;
        drive_start(1'b1, with_clear);
        tick(1);
        drive_start(1'b0, 1'b0);
        if (with_clear) check({tag, "_clr_iter"}, 32'(o_it), 32'd0);
        bcnt = o_busy ? 1 : 0;
        lat  = -1;
        if (chg_idx >= 0) d[chg_idx] = chg_val;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (o_done) begin
                lat = k;
                break;
            end
            if (o_busy) bcnt++;
            if (poke && k == 5) drive_start(1'b1, 1'b1);
            if (poke && k == 6) drive_start(1'b0, 1'b0);
        end
        check({tag, "_latency"}, 32'(lat), 32'd17);
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'd17);
        check({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
    endtask

    task automatic count_dones(input int n, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            tick(1);
            if (o_done) c++;
        end
    endtask

    int nd;

    // Directed sequence.
    initial begin
        rst = 1'b1; start0 = 1'b0; clear0 = 1'b0; start3 = 1'b0; clear3 = 1'b0;
        set_d(-1, 26'sd0, 26'sd0);
        tick(2);
        rst = 1'b0;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_flags", {29'd0, o_conv, o_next, o_to}, 32'd0);
        check("rst_max", 32'(o_max), 32'd0);
        check("rst_iter", 32'(o_it), 32'd0);

        // All zero -> converged at max 0, index 0.
        do_pass("zero", 1'b0, -1, 26'sd0, 1'b0);
        check("zero_conv", 32'(o_conv), 32'd1);
        check("zero_next", 32'(o_next), 32'd0);
        check("zero_max", 32'(o_max), 32'd0);
        check("zero_idx", 32'(o_idx), 32'd0);
        check("zero_iter", 32'(o_it), 32'd1);
        tick(1);
        check("zero_done_one_cycle", 32'(o_done), 32'd0);

        // Clear alone in IDLE.
        clear0 = 1'b1; tick(1); clear0 = 1'b0;
        check("clear_iter", 32'(o_it), 32'd0);
        check("clear_busy", 32'(o_busy), 32'd0);

        // d23 = 500, others 10.
        set_d(6, 26'sd500, 26'sd10);
        do_pass("d23_500", 1'b0, -1, 26'sd0, 1'b0);
        check("d23_500_max", 32'(o_max), 32'd500);
        check("d23_500_idx", 32'(o_idx), 32'd6);
        check("d23_500_flags", {29'd0, o_conv, o_next, o_to}, 32'b010);
        check("d23_500_iter", 32'(o_it), 32'd1);

        // Tolerance boundary.
        d[6] = 26'sd82;
        do_pass("tol_eq", 1'b0, -1, 26'sd0, 1'b0);
        check("tol_eq_flags", {29'd0, o_conv, o_next, o_to}, 32'b100);
        check("tol_eq_max", 32'(o_max), 32'd82);
        d[6] = 26'sd83;
        do_pass("tol_p1", 1'b0, -1, 26'sd0, 1'b0);
        check("tol_p1_flags", {29'd0, o_conv, o_next, o_to}, 32'b010);
        check("tol_p1_max", 32'(o_max), 32'd83);

        // Tie keeps lower index; input change after capture is ignored.
        set_d(-1, 26'sd0, 26'sd0);
        d[1] = 26'sd300; d[12] = 26'sd300;
        do_pass("tie", 1'b0, 1, 26'sd0, 1'b0);
        check("tie_max", 32'(o_max), 32'd300);
        check("tie_idx", 32'(o_idx), 32'd1);

        // Negative value saturates and never converges.
        set_d(15, -26'sd5, 26'sd0);
        do_pass("neg", 1'b0, -1, 26'sd0, 1'b0);
        check("neg_max", 32'(o_max), 32'h01FF_FFFF);
        check("neg_idx", 32'(o_idx), 32'd15);
        check("neg_flags", {29'd0, o_conv, o_next, o_to}, 32'b010);

        // Timeout on the MAX_ITER = 3 instance.
        sel = 1'b1;
        set_d(0, 26'sd1000, 26'sd0);
        do_pass("to_p1", 1'b0, -1, 26'sd0, 1'b0);
        check("to_p1_flags", {29'd0, o_conv, o_next, o_to}, 32'b010);
        check("to_p1_iter", 32'(o_it), 32'd1);
        do_pass("to_p2", 1'b0, -1, 26'sd0, 1'b0);
        check("to_p2_flags", {29'd0, o_conv, o_next, o_to}, 32'b010);
        do_pass("to_p3", 1'b0, -1, 26'sd0, 1'b0);
        check("to_p3_flags", {29'd0, o_conv, o_next, o_to}, 32'b001);
        check("to_p3_iter", 32'(o_it), 32'd3);
        drive_start(1'b1, 1'b0); tick(1); drive_start(1'b0, 1'b0);
        check("to_p4_busy", 32'(o_busy), 32'd0);
        count_dones(25, nd);
        check("to_p4_dones", 32'(nd), 32'd0);
        check("to_p4_timeout_held", 32'(o_to), 32'd1);
        do_pass("to_clr", 1'b1, -1, 26'sd0, 1'b0);
        check("to_clr_iter", 32'(o_it), 32'd1);
        check("to_clr_flags", {29'd0, o_conv, o_next, o_to}, 32'b010);
        sel = 1'b0;

        // Reset in the middle of a scan (index 7).
        drive_start(1'b1, 1'b0); tick(1); drive_start(1'b0, 1'b0);
        tick(7);
        check("mid_busy_before_rst", 32'(o_busy), 32'd1);
        rst = 1'b1; tick(1); rst = 1'b0;
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_flags", {29'd0, o_conv, o_next, o_to}, 32'd0);
        check("mid_rst_max", 32'(o_max), 32'd0);
        check("mid_rst_iter", 32'(o_it), 32'd0);
        count_dones(25, nd);
        check("mid_rst_no_done", 32'(nd), 32'd0);

        // Fresh pass after reset, then a pass with start+clear poked mid-scan.
        set_d(6, 26'sd83, 26'sd0);
        do_pass("fresh", 1'b0, -1, 26'sd0, 1'b0);
        check("fresh_flags", {29'd0, o_conv, o_next, o_to}, 32'b010);
        check("fresh_iter", 32'(o_it), 32'd1);
        do_pass("poke", 1'b0, -1, 26'sd0, 1'b1);
        check("poke_iter", 32'(o_it), 32'd2);
        count_dones(25, nd);
        check("poke_single_done", 32'(nd), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
